// File: rtl/snn_pkg.sv
// Shared definitions for the spike train player: FSM state encoding and the
// bit layout of one event-table word {label, eop, channel}.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CH_LSB  = 0;
  localparam int EPOCH_W = 16;

  // The channel field occupies [cw-1:0]; eop sits just above it, label above that.
  function automatic int eop_pos(input int cw);
    return cw;
  endfunction

  function automatic int label_lsb(input int cw);
    return cw + 1;
  endfunction

endpackage

// File: rtl/spike_event_ram.sv
// Simple dual-port event table: one synchronous write port, one registered read port.
module spike_event_ram #(
  parameter  int p_depth = 1024,
  parameter  int p_width = 11,
  localparam int AW      = $clog2(p_depth)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [p_width-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [p_width-1:0] o_rd_data
);

  logic [p_width-1:0] mem [p_depth];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/spike_train_player.sv
// Replays a stored table of spike events into an SNN core for a fixed number of epochs.
// Define SPIKE_LABEL_EN to emit a one-hot supervision label alongside end-of-pattern events.
module spike_train_player
  import snn_pkg::*;
#(
  parameter  int p_s             = 100,
  parameter  int p_n             = 5,
  parameter  int p_depth         = 1024,
  parameter  int p_spike_delay   = 4,
  parameter  int p_pattern_delay = 4,
  parameter  int p_epochs        = 100,
  localparam int CW              = $clog2(p_s),
  localparam int LW              = $clog2(p_n),
  localparam int AW              = $clog2(p_depth),
  localparam int EW              = CW + LW + 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_wr_en,
  input  logic [AW-1:0]  i_wr_addr,
  input  logic [EW-1:0]  i_wr_data,
  input  logic [AW:0]    i_len,
  input  logic           i_start,
  input  logic           i_stop,
  output logic [p_s-1:0] o_event,
  output logic [p_n-1:0] o_label,
  output logic           o_busy,
  output logic           o_end_of_epochs,
  output logic [15:0]    o_epoch
);

  localparam int EOP      = eop_pos(CW);
  localparam int LBL      = label_lsb(CW);
  localparam int DLY_MAX  = (p_spike_delay > p_pattern_delay) ? p_spike_delay : p_pattern_delay;
  localparam int DW       = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int SPK_LOAD = (p_spike_delay > 0) ? p_spike_delay - 1 : 0;
  localparam int PAT_LOAD = (p_pattern_delay > 0) ? p_pattern_delay - 1 : 0;

  function automatic logic [EPOCH_W-1:0] sat_inc(input logic [EPOCH_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [p_s-1:0] onehot_ch(input logic [CW-1:0] c);
    onehot_ch = '0;
    if (int'(c) < p_s) onehot_ch[c] = 1'b1;
  endfunction

  state_t             state, state_nxt;
  logic [AW:0]        len_q;
  logic [AW-1:0]      addr_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [EPOCH_W-1:0] epoch_inc;
  logic               eoe_q;
  logic [DW-1:0]      wait_q;
  logic [EW-1:0]      rd_data_p1;
  logic [CW-1:0]      ch;
  logic               eop;
  logic               last;
  logic               run_done;
  logic               dly_zero;
  logic               start_ok;

  spike_event_ram #(
    .p_depth (p_depth),
    .p_width (EW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en && !o_busy),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (state == FETCH),
    .i_rd_addr (addr_q),
    .o_rd_data (rd_data_p1)
  );

  assign ch        = rd_data_p1[CW-1:CH_LSB];
  assign eop       = rd_data_p1[EOP];
  assign last      = ({1'b0, addr_q} == (len_q - 1'b1));
  assign epoch_inc = sat_inc(epoch_q);
  assign run_done  = last && (int'(epoch_inc) == p_epochs);
  assign dly_zero  = eop ? (p_pattern_delay == 0) : (p_spike_delay == 0);
  assign start_ok  = (state == IDLE) && i_start && !i_stop && (i_len != '0);

`ifdef SPIKE_LABEL_EN
  logic [LW-1:0] lbl;
  assign lbl = rd_data_p1[EW-1:LBL];

  function automatic logic [p_n-1:0] onehot_label(input logic [LW-1:0] l);
    onehot_label = '0;
    if (int'(l) < p_n) onehot_label[l] = 1'b1;
  endfunction
`else
  logic unused_label;
  assign unused_label = ^rd_data_p1[EW-1:LBL];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   state_nxt = EMIT;
      EMIT: begin
        if (run_done)      state_nxt = DONE;
        else if (dly_zero) state_nxt = FETCH;
        else               state_nxt = WAIT;
      end
      WAIT:    if (wait_q == '0) state_nxt = FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over every other transition.
    if (i_stop) state_nxt = IDLE;
  end

  always_comb begin
    o_event = '0;
    o_label = '0;
    o_busy  = (state == FETCH) || (state == EMIT) || (state == WAIT);
    if (state == EMIT && !i_stop) begin
      o_event = onehot_ch(ch);
`ifdef SPIKE_LABEL_EN
      if (eop) o_label = onehot_label(lbl);
`endif
    end
  end

  // Sequencing counters freeze while stop is asserted so the epoch count is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q   <= '0;
      addr_q  <= '0;
      epoch_q <= '0;
      eoe_q   <= 1'b0;
      wait_q  <= '0;
    end else if (!i_stop) begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q   <= i_len;
            addr_q  <= '0;
            epoch_q <= '0;
            eoe_q   <= 1'b0;
          end
        end
        EMIT: begin
          addr_q <= last ? '0 : addr_q + 1'b1;
          if (last)     epoch_q <= epoch_inc;
          if (run_done) eoe_q   <= 1'b1;
          wait_q <= eop ? DW'(PAT_LOAD) : DW'(SPK_LOAD);
        end
        WAIT:    wait_q <= wait_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_end_of_epochs = eoe_q;
  assign o_epoch         = epoch_q;

endmodule
